mult_resp_checker: RTL and testbench
====================================

MULT_RESP_CHECKER -- requirements
Module: mult_resp_checker

Interface
REQ-001 Parameter WIDTH SHALL default to 2 and sets the operand width; legal range is 2..16.
REQ-002 Parameter CNT_W SHALL default to 16 and sets the width of the match and error counters.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: an operand/product triple is presented.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the checker can accept a triple.
REQ-007 Port in_a SHALL be an input, WIDTH bits wide: multiplicand driven to the DUT.
REQ-008 Port in_b SHALL be an input, WIDTH bits wide: multiplier driven to the DUT.
REQ-009 Port in_p SHALL be an input, 2*WIDTH bits wide: product returned by the DUT.
REQ-010 Port clear SHALL be an input, 1 bit wide: synchronous clear of counters and first-fail capture.
REQ-011 Port res_valid SHALL be an output, 1 bit wide: one-cycle pulse marking a verdict.
REQ-012 Port res_match SHALL be an output, 1 bit wide: verdict, where 1 means in_p equalled the golden product.
REQ-013 Port res_expected SHALL be an output, 2*WIDTH bits wide: the golden product.
REQ-014 Port match_cnt SHALL be an output, CNT_W bits wide: number of matching triples.
REQ-015 Port err_cnt SHALL be an output, CNT_W bits wide: number of mismatching triples.
REQ-016 Port fail_seen SHALL be an output, 1 bit wide: sticky flag set by any mismatch.
REQ-017 Ports fail_a, fail_b and fail_p SHALL be outputs, WIDTH, WIDTH and 2*WIDTH bits wide: the operands and DUT product of the first mismatch.

Function
REQ-018 A transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; at that edge in_a, in_b and in_p SHALL be registered internally.
REQ-019 The FSM SHALL have three states: IDLE, MUL and CMP.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 On a transfer in IDLE, the FSM SHALL go to MUL with the accumulator at 0 and the step counter at 0.
REQ-022 MUL SHALL run a shift-add multiply, one multiplier bit per cycle, LSB first, adding (a << step) to the accumulator when the bit is 1.
REQ-023 MUL SHALL last exactly WIDTH cycles and then go to CMP.
REQ-024 All multiply arithmetic SHALL be unsigned and 2*WIDTH bits wide; no overflow is possible.
REQ-025 In CMP, res_valid SHALL be 1 for exactly one cycle, res_match SHALL equal (acc == captured p), and res_expected SHALL equal acc; the FSM SHALL then return to IDLE.
REQ-026 Latency: the verdict SHALL appear WIDTH+1 cycles after the transfer edge, and the next transfer SHALL be possible one cycle after the verdict.
REQ-027 res_match and res_expected SHALL hold their values until the next verdict.
REQ-028 In the CMP cycle, match_cnt or err_cnt SHALL increment by 1 and SHALL saturate at all-ones.
REQ-029 On the first mismatch while fail_seen is 0, fail_seen SHALL be set to 1 and fail_a, fail_b and fail_p SHALL capture the registered triple.
REQ-030 Later mismatches SHALL leave fail_a, fail_b and fail_p unchanged.
REQ-031 clear SHALL zero both counters, fail_seen and the fail_* outputs.
REQ-032 When clear coincides with the CMP cycle, clear SHALL win: the counter increment and the capture are dropped, but the res_valid pulse still fires.
REQ-033 clear SHALL NOT affect the FSM or an in-flight multiply.
REQ-034 in_valid asserted outside IDLE SHALL be ignored; the inputs SHALL NOT be sampled.
REQ-035 Input values SHALL be don't-care when no transfer occurs.

Reset
REQ-036 While rst is 1, the FSM SHALL be in IDLE and in_ready SHALL be 1.
REQ-037 While rst is 1, res_valid, res_match, res_expected, match_cnt, err_cnt, fail_seen, fail_a, fail_b and fail_p SHALL all be 0.
REQ-038 rst asserted during MUL or CMP SHALL abort the operation; no verdict SHALL be produced and no counter SHALL change.
REQ-039 rst SHALL have priority over clear and over a transfer.

Structure
REQ-040 A shared package SHALL hold the FSM state enum (IDLE, MUL, CMP) and the default WIDTH and CNT_W constants.
REQ-041 The shift-add datapath SHALL be one sub-module, mult_shift_add_core, with start, done, a, b and acc ports; the FSM, counters and capture logic SHALL stay in the top module.

Verification
REQ-042 With WIDTH=2, transfer (a=3, b=3, p=9) -> res_valid 3 cycles later, res_match=1, res_expected=9, match_cnt=1.
REQ-043 With WIDTH=2, transfer (3, 1, 4) -> res_match=0, res_expected=3, err_cnt=1, fail_seen=1, fail_a=3, fail_b=1, fail_p=4; a later mismatch (2, 2, 5) -> fail_* unchanged, err_cnt=2.
REQ-044 With in_valid held high for 20 triples -> in_ready is low during MUL/CMP, exactly 20 verdicts, and match_cnt+err_cnt=20.
REQ-045 With WIDTH=8, transfer (255, 255, 65025) -> res_match=1 after 9 cycles; with CNT_W=2, 5 matches -> match_cnt=3 (saturated).
REQ-046 rst pulsed in the 2nd MUL cycle -> no res_valid, counters 0, in_ready=1 on the cycle after rst deasserts.
REQ-047 clear asserted in the CMP cycle of a mismatch -> res_valid=1, res_match=0, err_cnt=0, fail_seen=0.

Source files
------------

// File: rtl/mult_resp_checker_pkg.sv
// Shared types and default sizes for the multiplier response checker.
// Holds the checker FSM state encoding and the default operand/counter widths.
package mult_resp_checker_pkg;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_resp_checker_mult.sv
// Shift-add multiplier: one multiplier bit per cycle, LSB first.
// start clears the accumulator; done is high during the last multiply cycle.
module mult_shift_add_core
    import mult_resp_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   acc
);

    localparam int SW = $clog2(WIDTH);

    logic                 busy_q, busy_d;
    logic [SW-1:0]        step_q, step_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        acc_d  = acc_q;
        done   = 1'b0;
        if (start) begin
            busy_d = 1'b1;
            step_d = '0;
            acc_d  = '0;
        end else if (busy_q) begin
            if (b[step_q]) begin
                acc_d = acc_q + ({{WIDTH{1'b0}}, a} << step_q);
            end
            if (step_q == SW'(WIDTH - 1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
                step_d = '0;
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            step_q <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mult_resp_checker.sv
// Checks products returned by an external multiplier against a shift-add golden model,
// counting matches/mismatches and capturing the first failing triple.
//
// state | meaning
// IDLE  | ready for a triple; a transfer loads operands and starts the multiply
// MUL   | golden multiply running, WIDTH cycles
// CMP   | compare golden vs returned product; verdict registered at end of cycle
module mult_resp_checker
    import mult_resp_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2*WIDTH-1:0]   in_p,
    input  logic                 clear,
    output logic                 res_valid,
    output logic                 res_match,
    output logic [2*WIDTH-1:0]   res_expected,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 fail_seen,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [2*WIDTH-1:0]   fail_p
);

    state_e               state_q, state_d;
    logic                 xfer;
    logic                 mul_done;
    logic                 prod_ok;
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   p_q;

    logic                 res_valid_q, res_valid_d;
    logic                 res_match_q, res_match_d;
    logic [2*WIDTH-1:0]   res_exp_q, res_exp_d;
    logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 fail_seen_q, fail_seen_d;
    logic [WIDTH-1:0]     fail_a_q, fail_a_d;
    logic [WIDTH-1:0]     fail_b_q, fail_b_d;
    logic [2*WIDTH-1:0]   fail_p_q, fail_p_d;

    assign xfer    = in_valid && (state_q == IDLE);
    assign prod_ok = (acc == p_q);

    mult_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (xfer),
        .a     (a_q),
        .b     (b_q),
        .done  (mul_done),
        .acc   (acc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL;
            MUL:     if (mul_done) state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // clear beats the CMP-cycle update, but the verdict itself is still published
    always_comb begin
        res_valid_d = (state_q == CMP);
        res_match_d = res_match_q;
        res_exp_d   = res_exp_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        fail_seen_d = fail_seen_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_p_d    = fail_p_q;

        if (state_q == CMP) begin
            res_match_d = prod_ok;
            res_exp_d   = acc;
        end

        if (clear) begin
            match_cnt_d = '0;
            err_cnt_d   = '0;
            fail_seen_d = 1'b0;
            fail_a_d    = '0;
            fail_b_d    = '0;
            fail_p_d    = '0;
        end else if (state_q == CMP) begin
            if (prod_ok) begin
                if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CNT_W'(1);
            end else begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                if (!fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    fail_a_d    = a_q;
                    fail_b_d    = b_q;
                    fail_p_d    = p_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_exp_q   <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            fail_seen_q <= 1'b0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_p_q    <= '0;
        end else begin
            state_q     <= state_d;
            if (xfer) begin
                a_q <= in_a;
                b_q <= in_b;
                p_q <= in_p;
            end
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            res_exp_q   <= res_exp_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fail_seen_q <= fail_seen_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_p_q    <= fail_p_d;
        end
    end

    // Outputs read as reset values for the whole time rst is high, not just after its first edge
    assign in_ready     = rst || (state_q == IDLE);
    assign res_valid    = rst ? 1'b0 : res_valid_q;
    assign res_match    = rst ? 1'b0 : res_match_q;
    assign res_expected = rst ? '0   : res_exp_q;
    assign match_cnt    = rst ? '0   : match_cnt_q;
    assign err_cnt      = rst ? '0   : err_cnt_q;
    assign fail_seen    = rst ? 1'b0 : fail_seen_q;
    assign fail_a       = rst ? '0   : fail_a_q;
    assign fail_b       = rst ? '0   : fail_b_q;
    assign fail_p       = rst ? '0   : fail_p_q;

endmodule

// File: tb/tb_mult_resp_checker.sv
// Bench for mult_resp_checker: a WIDTH=2 instance and a WIDTH=8/CNT_W=2 instance,
// each compared every cycle against a transaction-level model, plus literal spot checks.
module tb_mult_resp_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v, clr_v, val_v;
    logic [7:0]  a_v [2];
    logic [7:0]  b_v [2];
    logic [15:0] p_v [2];

    logic        rdy0, rv0, rm0, fs0;
    logic [3:0]  re0, fp0;
    logic [15:0] mc0, ec0;
    logic [1:0]  fa0, fb0;

    logic        rdy1, rv1, rm1, fs1;
    logic [15:0] re1, fp1;
    logic [1:0]  mc1, ec1;
    logic [7:0]  fa1, fb1;

    mult_resp_checker #(.WIDTH(2), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst_v[0]), .in_valid(val_v[0]), .in_ready(rdy0),
        .in_a(a_v[0][1:0]), .in_b(b_v[0][1:0]), .in_p(p_v[0][3:0]), .clear(clr_v[0]),
        .res_valid(rv0), .res_match(rm0), .res_expected(re0),
        .match_cnt(mc0), .err_cnt(ec0), .fail_seen(fs0),
        .fail_a(fa0), .fail_b(fb0), .fail_p(fp0)
    );

    mult_resp_checker #(.WIDTH(8), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst_v[1]), .in_valid(val_v[1]), .in_ready(rdy1),
        .in_a(a_v[1]), .in_b(b_v[1]), .in_p(p_v[1]), .clear(clr_v[1]),
        .res_valid(rv1), .res_match(rm1), .res_expected(re1),
        .match_cnt(mc1), .err_cnt(ec1), .fail_seen(fs1),
        .fail_a(fa1), .fail_b(fb1), .fail_p(fp1)
    );

    // field index: 0 ready 1 valid 2 match 3 expected 4 mcnt 5 ecnt 6 fseen 7 fa 8 fb 9 fp
    logic [15:0] act [2][10];
    string fname [10] = '{"in_ready", "res_valid", "res_match", "res_expected", "match_cnt",
                          "err_cnt", "fail_seen", "fail_a", "fail_b", "fail_p"};

    always_comb begin
        act[0][0] = {15'b0, rdy0};  act[1][0] = {15'b0, rdy1};
        act[0][1] = {15'b0, rv0};   act[1][1] = {15'b0, rv1};
        act[0][2] = {15'b0, rm0};   act[1][2] = {15'b0, rm1};
        act[0][3] = {12'b0, re0};   act[1][3] = re1;
        act[0][4] = mc0;            act[1][4] = {14'b0, mc1};
        act[0][5] = ec0;            act[1][5] = {14'b0, ec1};
        act[0][6] = {15'b0, fs0};   act[1][6] = {15'b0, fs1};
        act[0][7] = {14'b0, fa0};   act[1][7] = {8'b0, fa1};
        act[0][8] = {14'b0, fb0};   act[1][8] = {8'b0, fb1};
        act[0][9] = {12'b0, fp0};   act[1][9] = fp1;
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int vcount0 = 0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act_v, exp_v, $time);
        end
    endtask

    // Transaction model: verdict lands W+1 edges after the accepting edge, product by plain multiply.
    int m_w [2]    = '{2, 8};
    int m_cmax [2] = '{65535, 3};
    int m_amask [2] = '{3, 255};
    int m_pmask [2] = '{15, 65535};
    int cyc = 0;
    int m_busy [2], m_due [2], m_a [2], m_b [2], m_p [2];
    int m_rv [2], m_rm [2], m_re [2], m_mc [2], m_ec [2], m_fs [2], m_fa [2], m_fb [2], m_fp [2];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k]) begin
                m_busy[k] = 0; m_rv[k] = 0; m_rm[k] = 0; m_re[k] = 0;
                m_mc[k] = 0; m_ec[k] = 0; m_fs[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_fp[k] = 0;
            end else begin
                automatic bit was_idle = (m_busy[k] == 0);
                automatic int prod;
                m_rv[k] = 0;
                if (m_busy[k] != 0 && cyc == m_due[k]) begin
                    prod = m_a[k] * m_b[k];
                    m_rv[k] = 1;
                    m_rm[k] = (prod == m_p[k]) ? 1 : 0;
                    m_re[k] = prod;
                    m_busy[k] = 0;
                    if (!clr_v[k]) begin
                        if (m_rm[k] == 1) begin
                            if (m_mc[k] < m_cmax[k]) m_mc[k]++;
                        end else begin
                            if (m_ec[k] < m_cmax[k]) m_ec[k]++;
                            if (m_fs[k] == 0) begin
                                m_fs[k] = 1; m_fa[k] = m_a[k]; m_fb[k] = m_b[k]; m_fp[k] = m_p[k];
                            end
                        end
                    end
                end
                if (clr_v[k]) begin
                    m_mc[k] = 0; m_ec[k] = 0; m_fs[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_fp[k] = 0;
                end
                if (was_idle && val_v[k]) begin
                    m_busy[k] = 1;
                    m_due[k]  = cyc + m_w[k] + 1;
                    m_a[k] = int'(a_v[k]) & m_amask[k];
                    m_b[k] = int'(b_v[k]) & m_amask[k];
                    m_p[k] = int'(p_v[k]) & m_pmask[k];
                end
            end
        end
    end

    function automatic int model_field(int k, int f);
        if (rst_v[k]) return (f == 0) ? 1 : 0;
        case (f)
            0: return (m_busy[k] != 0) ? 0 : 1;
            1: return m_rv[k];
            2: return m_rm[k];
            3: return m_re[k];
            4: return m_mc[k];
            5: return m_ec[k];
            6: return m_fs[k];
            7: return m_fa[k];
            8: return m_fb[k];
            default: return m_fp[k];
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++)
                for (int f = 0; f < 10; f++)
                    chk($sformatf("dut%0d %s", k, fname[f]), 32'(act[k][f]), model_field(k, f));
            if (rv0 === 1'b1) vcount0++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int k, input int a, input int b, input int p);
        int n = 0;
        while (act[k][0] !== 16'd1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("xfer ready timeout", n, 0);
        val_v[k] = 1'b1; a_v[k] = 8'(a); b_v[k] = 8'(b); p_v[k] = 16'(p);
        step();
        val_v[k] = 1'b0;
    endtask

    task automatic wait_verdict(input int k, input int exp_lat, input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (act[k][1] !== 16'd1 && n < 40);
        chk(nm, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nx, guard, v_start, nv;
        int ta, tb, tp;
        int m45 [4][3] = '{'{10, 20, 200}, '{0, 7, 0}, '{128, 2, 256}, '{17, 15, 255}};

        rst_v = 2'b11; clr_v = 2'b00; val_v = 2'b00;
        for (int k = 0; k < 2; k++) begin a_v[k] = '0; b_v[k] = '0; p_v[k] = '0; end
        repeat (3) step();
        chk_en = 1'b1;
        chk("reset in_ready", act[0][0], 1);
        chk("reset res_valid", act[0][1], 0);
        chk("reset match_cnt", act[1][4], 0);
        step();
        rst_v = 2'b00;
        step();

        // (3,3,9): match
        xfer(0, 3, 3, 9);
        wait_verdict(0, 3, "r042 latency");
        chk("r042 res_match", act[0][2], 1);
        chk("r042 res_expected", act[0][3], 9);
        chk("r042 match_cnt", act[0][4], 1);

        // (3,1,4) first mismatch, then (2,2,5) leaves capture alone
        xfer(0, 3, 1, 4);
        wait_verdict(0, 3, "r043a latency");
        chk("r043a res_match", act[0][2], 0);
        chk("r043a res_expected", act[0][3], 3);
        chk("r043a err_cnt", act[0][5], 1);
        chk("r043a fail_seen", act[0][6], 1);
        chk("r043a fail_a", act[0][7], 3);
        chk("r043a fail_b", act[0][8], 1);
        chk("r043a fail_p", act[0][9], 4);
        xfer(0, 2, 2, 5);
        wait_verdict(0, 3, "r043b latency");
        chk("r043b res_expected", act[0][3], 4);
        chk("r043b err_cnt", act[0][5], 2);
        chk("r043b fail_a", act[0][7], 3);
        chk("r043b fail_p", act[0][9], 4);
        repeat (3) step();
        chk("hold res_expected", act[0][3], 4);

        clr_v[0] = 1'b1;
        step();
        clr_v[0] = 1'b0;
        chk("clear match_cnt", act[0][4], 0);
        chk("clear fail_seen", act[0][6], 0);

        // 20 back-to-back triples with in_valid held high
        v_start = vcount0;
        nx = 0; guard = 0;
        ta = 0; tb = 0; tp = 1;
        val_v[0] = 1'b1; a_v[0] = 8'(ta); b_v[0] = 8'(tb); p_v[0] = 16'(tp);
        while (nx < 20 && guard < 500) begin
            automatic bit will = (act[0][0] === 16'd1);
            step();
            guard++;
            if (will) begin
                nx++;
                ta = nx % 4; tb = (nx / 4) % 4;
                tp = (nx % 3 == 0) ? ((ta * tb) ^ 1) : ta * tb;
                a_v[0] = 8'(ta); b_v[0] = 8'(tb); p_v[0] = 16'(tp);
            end
        end
        val_v[0] = 1'b0;
        if (guard >= 500) chk("r044 transfer timeout", guard, 0);
        repeat (6) step();
        chk("r044 verdicts", vcount0 - v_start, 20);
        chk("r044 cnt sum", act[0][4] + act[0][5], 20);

        // clear lands in the CMP cycle of a mismatch
        xfer(0, 1, 1, 0);
        step();
        step();
        clr_v[0] = 1'b1;
        step();
        clr_v[0] = 1'b0;
        chk("r047 res_valid", act[0][1], 1);
        chk("r047 res_match", act[0][2], 0);
        chk("r047 err_cnt", act[0][5], 0);
        chk("r047 fail_seen", act[0][6], 0);

        // reset in the second MUL cycle aborts the multiply
        xfer(0, 2, 3, 6);
        step();
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        chk("r046 in_ready", act[0][0], 1);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (act[0][1] === 16'd1) nv++;
            step();
        end
        chk("r046 no verdict", nv, 0);
        chk("r046 match_cnt", act[0][4], 0);
        chk("r046 err_cnt", act[0][5], 0);
        xfer(0, 2, 3, 6);
        wait_verdict(0, 3, "r046 recover latency");
        chk("r046 recover match", act[0][2], 1);

        // WIDTH=8 latency and CNT_W=2 saturation
        xfer(1, 255, 255, 65025);
        wait_verdict(1, 9, "r045 latency");
        chk("r045 res_match", act[1][2], 1);
        chk("r045 res_expected", act[1][3], 65025);
        for (int i = 0; i < 4; i++) begin
            xfer(1, m45[i][0], m45[i][1], m45[i][2]);
            wait_verdict(1, 9, "r045 loop latency");
        end
        chk("r045 match_cnt sat", act[1][4], 3);
        xfer(1, 1, 1, 2);
        wait_verdict(1, 9, "r045 miss latency");
        chk("r045 err_cnt", act[1][5], 1);
        chk("r045 fail_p", act[1][9], 2);
        chk("r045 match_cnt held", act[1][4], 3);

        repeat (2) step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
